// File: rtl/cache_flush_sweep_engine_pkg.sv
// Shared types and constants for the cache flush sweep engine.
// Cache geometry is passed to the modules as parameters, so nothing here is tied to one cache size.
package cache_flush_sweep_engine_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } sweep_state_e;

  localparam logic ModeLinear   = 1'b0;
  localparam logic ModeSetAlias = 1'b1;

  localparam int unsigned ReqAddrW = 64;

  typedef struct packed {
    logic                valid;
    logic [ReqAddrW-1:0] address;
  } sweep_req_t;

endpackage

// File: rtl/cache_flush_address_calc.sv
// Combinational map from sweep mode and line counter to a line address.
// The parent module registers the result.
module cache_flush_address_calc
  import cache_flush_sweep_engine_pkg::*;
#(
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned CACHE_SIZE = 65536,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned COUNT_W    = 11
) (
  input  logic               mode_i,
  input  logic [ADDR_W-1:0]  base_i,
  input  logic [COUNT_W-1:0] count_i,
  output logic [ADDR_W-1:0]  addr_o
);

  localparam int unsigned LineLog = $clog2(LINE_BYTES);
  localparam int unsigned WayLog  = $clog2(NUM_WAYS);
  localparam int unsigned NumSets = CACHE_SIZE >> (LineLog + WayLog);
  localparam int unsigned SetLog  = $clog2(NumSets);

  logic [ADDR_W-1:0] count_ext, way_idx, set_idx, offset;

  always_comb begin
    count_ext = ADDR_W'(count_i);
    way_idx   = count_ext & ADDR_W'(NUM_WAYS - 1);
    set_idx   = count_ext >> WayLog;
    // Ways vary fastest, so every way of a set is touched before moving to the next set
    if (mode_i == ModeSetAlias) begin
      offset = (set_idx << LineLog) + (way_idx << (LineLog + SetLog));
    end else begin
      offset = count_ext << LineLog;
    end
    addr_o = base_i + offset;
  end

endmodule

// File: rtl/cache_flush_sweep_engine.sv
// Issues one line-sized read per cache line to evict the cache.
// Supports a limit on outstanding reads, waits for all responses, and can be aborted.
module cache_flush_sweep_engine
  import cache_flush_sweep_engine_pkg::*;
#(
  parameter int unsigned NUM_WAYS        = 4,
  parameter int unsigned CACHE_SIZE      = 65536,
  parameter int unsigned LINE_BYTES      = 64,
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = 16,
  localparam int unsigned LineCount      = CACHE_SIZE / LINE_BYTES,
  localparam int unsigned CountW         = $clog2(LineCount) + 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start_in,
  input  logic              mode_in,
  input  logic [ADDR_W-1:0] base_address_in,
  input  logic [CountW-1:0] num_lines_in,
  input  logic              abort_in,
  output logic              req_valid_out,
  input  logic              req_ready_in,
  output logic [ADDR_W-1:0] req_address_out,
  input  logic              resp_valid_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              aborted_out,
  output logic              error_out,
  output logic [CountW-1:0] issued_count_out
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  sweep_state_e      state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CountW-1:0] target_q, target_d, issued_q, issued_d, target_clamped;
  logic [OutW-1:0]   out_q, out_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d, calc_addr;
  logic              error_q, error_d, aborted_q, aborted_d;
  logic              start_acc, req_fire, resp_ok;

  assign start_acc = (state_q == StIdle) && start_in;
  // Abort masks a pending request immediately so nothing more transfers
  assign req_fire  = req_valid_q && !abort_in && req_ready_in;
  assign resp_ok   = resp_valid_in && (out_q != '0);
  assign target_clamped = ((num_lines_in == '0) || (num_lines_in > CountW'(LineCount)))
                          ? CountW'(LineCount) : num_lines_in;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_in) state_d = StIssue;
      StIssue: if (abort_in || (issued_q == target_q)) state_d = StDrain;
      StDrain: if (out_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d    = mode_q;
    base_d    = base_q;
    target_d  = target_q;
    issued_d  = issued_q + CountW'(req_fire);
    out_d     = out_q + OutW'(req_fire) - OutW'(resp_ok);
    error_d   = error_q;
    aborted_d = aborted_q;
    if (start_acc) begin
      mode_d    = mode_in;
      base_d    = base_address_in;
      target_d  = target_clamped;
      issued_d  = '0;
      out_d     = '0;
      error_d   = 1'b0;
      aborted_d = 1'b0;
    end
    if (resp_valid_in && (out_q == '0)) error_d = 1'b1;
    if ((state_q == StIssue) && abort_in) aborted_d = 1'b1;
    // First request appears one cycle after entering ISSUE, since state_q must already be ISSUE
    req_valid_d = (state_q == StIssue) && (state_d == StIssue) && (issued_d < target_q)
                  && (out_d < OutW'(MAX_OUTSTANDING));
    req_addr_d  = req_valid_d ? calc_addr : req_addr_q;
  end

  cache_flush_address_calc #(
    .NUM_WAYS  (NUM_WAYS),
    .CACHE_SIZE(CACHE_SIZE),
    .LINE_BYTES(LINE_BYTES),
    .ADDR_W    (ADDR_W),
    .COUNT_W   (CountW)
  ) u_addr_calc (
    .mode_i (mode_q),
    .base_i (base_q),
    .count_i(issued_d),
    .addr_o (calc_addr)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mode_q      <= 1'b0;
      base_q      <= '0;
      target_q    <= '0;
      issued_q    <= '0;
      out_q       <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      error_q     <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      base_q      <= base_d;
      target_q    <= target_d;
      issued_q    <= issued_d;
      out_q       <= out_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      error_q     <= error_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    req_valid_out    = req_valid_q && !abort_in;
    req_address_out  = req_addr_q;
    busy_out         = (state_q != StIdle);
    done_out         = (state_q == StDone);
    aborted_out      = (state_q == StDone) && aborted_q;
    error_out        = error_q;
    issued_count_out = issued_q;
  end

endmodule

// File: tb/tb_cache_flush_sweep_engine.sv
// Randomized scoreboard bench for cache_flush_sweep_engine against an arithmetic address model.
module tb_cache_flush_sweep_engine;

  localparam int unsigned NWays     = 4;
  localparam int unsigned CacheSize = 65536;
  localparam int unsigned LineBytes = 64;
  localparam int unsigned AddrW     = 64;
  localparam int unsigned MaxOut    = 16;
  localparam int unsigned NSets     = CacheSize / (LineBytes * NWays);
  localparam int unsigned LineCount = NSets * NWays;
  localparam int unsigned CountW    = $clog2(LineCount) + 1;

  logic              ap_clk, ap_rst_n;
  logic              start_in, mode_in, abort_in, req_ready_in, resp_valid_in;
  logic [AddrW-1:0]  base_address_in;
  logic [CountW-1:0] num_lines_in;
  logic              req_valid_out, busy_out, done_out, aborted_out, error_out;
  logic [AddrW-1:0]  req_address_out;
  logic [CountW-1:0] issued_count_out;

  typedef struct {
    bit aborted;
    int count;
  } done_t;

  logic [63:0] exp_addr_q[$];
  done_t       done_q[$];
  int          pend_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          sweep_xfers = 0;
  int          done_seen = 0;
  int          resp_dmin = 0;
  int          resp_dmax = 3;
  bit          resp_hold = 0;
  int          resp_release = 0;
  bit          spur_req = 0;

  cache_flush_sweep_engine #(
    .NUM_WAYS       (NWays),
    .CACHE_SIZE     (CacheSize),
    .LINE_BYTES     (LineBytes),
    .ADDR_W         (AddrW),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .start_in        (start_in),
    .mode_in         (mode_in),
    .base_address_in (base_address_in),
    .num_lines_in    (num_lines_in),
    .abort_in        (abort_in),
    .req_valid_out   (req_valid_out),
    .req_ready_in    (req_ready_in),
    .req_address_out (req_address_out),
    .resp_valid_in   (resp_valid_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .aborted_out     (aborted_out),
    .error_out       (error_out),
    .issued_count_out(issued_count_out)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  always @(posedge ap_clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line c of a sweep: linear is base + c lines; set-aliasing walks all ways of set c/NWays first
  function automatic logic [63:0] model_addr(input bit mode, input logic [63:0] base, input int c);
    logic [63:0] way, set_i;
    if (!mode) return base + 64'(c) * 64'(LineBytes);
    way   = 64'(c % NWays);
    set_i = 64'(c / NWays);
    return base + set_i * 64'(LineBytes) + way * 64'(NSets * LineBytes);
  endfunction

  // Monitor: compares every transfer and every done pulse against the scoreboard
  initial begin
    logic        prev_stall;
    logic [63:0] prev_addr;
    done_t       d;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !abort_in) begin
          check("hold_valid", 64'(req_valid_out), 64'd1);
          check("hold_addr", req_address_out, prev_addr);
        end
        if (req_valid_out && req_ready_in) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got request 0x%0h, expected no request", req_address_out);
          end else begin
            check("req_addr", req_address_out, exp_addr_q.pop_front());
          end
          sweep_xfers++;
          pend_q.push_back(cyc + 1 + int'($urandom_range(resp_dmax, resp_dmin)));
        end
        if (done_out) begin
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done_out=1, expected 0");
          end else begin
            d = done_q.pop_front();
            check("done_aborted", 64'(aborted_out), 64'(d.aborted));
            check("done_count", 64'(issued_count_out), 64'(d.count));
            check("done_leftover", 64'(exp_addr_q.size()), 64'd0);
          end
          done_seen++;
        end
        prev_stall = req_valid_out && !req_ready_in;
        prev_addr  = req_address_out;
      end
    end
  end

  // Responder: one response per cycle, each no earlier than its scheduled cycle
  initial begin
    resp_valid_in = 1'b0;
    forever begin
      @(posedge ap_clk);
      #1;
      resp_valid_in = 1'b0;
      if (spur_req) begin
        resp_valid_in = 1'b1;
        spur_req = 1'b0;
      end else if (pend_q.size() > 0 && pend_q[0] <= cyc && (!resp_hold || resp_release > 0)) begin
        void'(pend_q.pop_front());
        resp_valid_in = 1'b1;
        if (resp_hold) resp_release--;
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_out || done_out) && n < 5000) begin
      tick();
      n++;
    end
    check("idle_timeout", 64'(busy_out), 64'd0);
  endtask

  task automatic start_sweep(input bit mode, input logic [63:0] base, input int num);
    int tgt;
    done_t d;
    wait_idle();
    tgt = (num == 0 || num > int'(LineCount)) ? int'(LineCount) : num;
    for (int c = 0; c < tgt; c++) exp_addr_q.push_back(model_addr(mode, base, c));
    d.aborted = 1'b0;
    d.count   = tgt;
    done_q.push_back(d);
    sweep_xfers     = 0;
    mode_in         = mode;
    base_address_in = base;
    num_lines_in    = CountW'(num);
    start_in        = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic drive_until_done(input int rdy_pct, input int abort_after, input int bound);
    int    seen0 = done_seen;
    int    n = 0;
    bit    ab = 1'b0;
    done_t d;
    while (done_seen == seen0 && n < bound) begin
      req_ready_in = ($urandom_range(99) < rdy_pct);
      abort_in = 1'b0;
      if (abort_after >= 0 && !ab && sweep_xfers >= abort_after) begin
        abort_in = 1'b1;
        ab = 1'b1;
        exp_addr_q.delete();
        d.aborted = 1'b1;
        d.count   = abort_after;
        done_q[done_q.size()-1] = d;
      end
      tick();
      n++;
    end
    abort_in = 1'b0;
    check("done_timeout", 64'(done_seen - seen0), 64'd1);
  endtask

  initial begin
    logic [63:0] addr0, base;
    int          n, num, tgt, ab_after, r;
    bit          mode;
    start_in = 1'b0;
    mode_in = 1'b0;
    base_address_in = '0;
    num_lines_in = '0;
    abort_in = 1'b0;
    req_ready_in = 1'b0;
    ap_rst_n = 1'b1;
    #1 ap_rst_n = 1'b0;
    #3;
    check("rst_valid", 64'(req_valid_out), 64'd0);
    check("rst_addr", req_address_out, 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_done", 64'(done_out), 64'd0);
    check("rst_aborted", 64'(aborted_out), 64'd0);
    check("rst_error", 64'(error_out), 64'd0);
    check("rst_count", 64'(issued_count_out), 64'd0);
    #20 ap_rst_n = 1'b1;
    tick();

    // Full set-aliasing sweep, continuous ready, responses 2 cycles later
    resp_dmin = 2;
    resp_dmax = 2;
    start_sweep(1'b1, 64'h1000, 0);
    drive_until_done(100, -1, 5000);

    // Short linear sweep
    start_sweep(1'b0, 64'h0, 3);
    drive_until_done(100, -1, 200);

    // Backpressure: valid and address must hold while ready is low
    req_ready_in = 1'b0;
    start_sweep(1'b0, 64'h2000, 4);
    n = 0;
    while (!req_valid_out && n < 20) begin
      tick();
      n++;
    end
    addr0 = req_address_out;
    check("bp_first_addr", addr0, model_addr(1'b0, 64'h2000, 0));
    repeat (5) begin
      tick();
      check("bp_addr_stable", req_address_out, addr0);
      check("bp_valid_held", 64'(req_valid_out), 64'd1);
    end
    check("bp_no_issue", 64'(sweep_xfers), 64'd0);
    drive_until_done(100, -1, 200);

    // Outstanding limit with responses withheld
    resp_dmin = 0;
    resp_dmax = 0;
    resp_hold = 1'b1;
    req_ready_in = 1'b1;
    start_sweep(1'b0, {$urandom, $urandom}, 40);
    repeat (40) tick();
    check("lim_issued", 64'(sweep_xfers), 64'(MaxOut));
    check("lim_valid_low", 64'(req_valid_out), 64'd0);
    resp_release = 1;
    repeat (10) tick();
    check("lim_one_more", 64'(sweep_xfers), 64'(MaxOut + 1));
    check("lim_valid_low2", 64'(req_valid_out), 64'd0);
    resp_hold = 1'b0;
    drive_until_done(100, -1, 500);

    // Abort after 10 transfers with about 4 outstanding
    resp_dmin = 4;
    resp_dmax = 4;
    start_sweep(1'b1, {$urandom, $urandom}, 40);
    drive_until_done(100, 10, 500);

    // Spurious response in idle sets the sticky error, next start clears it
    wait_idle();
    spur_req = 1'b1;
    repeat (3) tick();
    check("spur_err", 64'(error_out), 64'd1);
    repeat (4) tick();
    check("spur_err_sticky", 64'(error_out), 64'd1);
    check("spur_idle", 64'(busy_out), 64'd0);
    resp_dmin = 0;
    resp_dmax = 3;
    start_sweep(1'b0, {$urandom, $urandom}, 2);
    check("err_cleared", 64'(error_out), 64'd0);
    drive_until_done(100, -1, 200);
    check("err_stays_clear", 64'(error_out), 64'd0);

    // Randomized sweeps: mode, base (including wraparound), length, ready rate, delays, abort
    for (int k = 0; k < 12; k++) begin
      mode = 1'($urandom_range(1));
      base = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(255))
                                      : {$urandom, $urandom};
      r = int'($urandom_range(9));
      if (r == 0) num = 0;
      else if (r == 1) num = 1025 + int'($urandom_range(1022));
      else num = 1 + int'($urandom_range(59));
      tgt = (num == 0 || num > int'(LineCount)) ? int'(LineCount) : num;
      ab_after = -1;
      if (tgt > 1 && $urandom_range(3) == 0) ab_after = int'($urandom_range(tgt - 1));
      resp_dmin = 0;
      resp_dmax = int'($urandom_range(8));
      start_sweep(mode, base, num);
      drive_until_done(50 + int'($urandom_range(50)), ab_after, 40 * tgt + 500);
    end

    // Asynchronous reset in the middle of a sweep
    resp_dmin = 1;
    resp_dmax = 3;
    start_sweep(1'b1, 64'h0, 200);
    repeat (30) begin
      req_ready_in = 1'b1;
      tick();
    end
    #2 ap_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(req_valid_out), 64'd0);
    check("mid_rst_addr", req_address_out, 64'd0);
    check("mid_rst_busy", 64'(busy_out), 64'd0);
    check("mid_rst_done", 64'(done_out), 64'd0);
    check("mid_rst_count", 64'(issued_count_out), 64'd0);
    check("mid_rst_error", 64'(error_out), 64'd0);
    check("mid_rst_aborted", 64'(aborted_out), 64'd0);
    exp_addr_q.delete();
    done_q.delete();
    pend_q.delete();
    repeat (2) tick();
    ap_rst_n = 1'b1;
    tick();
    check("post_rst_idle", 64'(busy_out), 64'd0);
    start_sweep(1'b0, 64'h40, 5);
    drive_until_done(80, -1, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
